vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 raster timing for the game display path. Supplies the pixel coordinates (`pix_x`, `pix_y`) that the game/graphics logic consumes combinationally. Captures that logic's `graph_on`/`graph_rgb` result back into a registered output stage, with sync and data-enable delayed to match, for the HDMI/VGA encoder downstream.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `DIV`, 1, clk cycles per pixel (1..15)
- `SYNC_POL`, 0, active level of hsync/vsync
- `BG_RGB`, 3'b000, colour for visible pixels with `graph_on`=0

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous reset, active-low (asserted when 0)
- `graph_on`  in  1  graphics pixel valid, from game logic
- `graph_rgb`  in  3  graphics colour, from game logic
- `pix_x`  out  10  current column, 0..H_TOTAL-1
- `pix_y`  out  10  current line, 0..V_TOTAL-1
- `p_tick`  out  1  one-clk strobe: coordinates changed this cycle
- `video_on`  out  1  current (pix_x,pix_y) is visible
- `hsync`, `vsync`  out  1 each  sync for current coordinates
- `line_start`, `frame_start`  out  1 each  one-clk strobes
- `rgb_o`  out  3  registered pixel colour
- `hsync_o`, `vsync_o`, `de_o`  out  1 each  sync and data-enable aligned to `rgb_o`

## Operation
- H_TOTAL = 800, V_TOTAL = 525 with the default parameters.
- Divider `div_cnt` counts 0..DIV-1. An "advance edge" is any clk edge where `div_cnt`==DIV-1. With DIV=1, every edge is an advance edge.
- On an advance edge:
  - `pix_x` increments; at H_TOTAL-1 it wraps to 0 and `pix_y` increments.
  - At `pix_y`=V_TOTAL-1 together with the `pix_x` wrap, `pix_y` wraps to 0.
- All status outputs are registers, computed from the next counter values, so they always describe the current `pix_x`/`pix_y`:
  - `video_on` = x<H_DISPLAY && y<V_DISPLAY.
  - `hsync` = SYNC_POL when x in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] (656..751); otherwise ~SYNC_POL.
  - `vsync` = SYNC_POL when y in [490, 491]; otherwise ~SYNC_POL.
- `p_tick` is high for exactly the clk cycle after each advance edge.
- `line_start` = `p_tick` && `pix_x`==0.
- `frame_start` = `p_tick` && `pix_x`==0 && `pix_y`==0.
- Output stage samples the current pixel's values on each advance edge:
  - `rgb_o` = !`video_on` ? 0 : (`graph_on` ? `graph_rgb` : BG_RGB).
  - `hsync_o` ⇐ `hsync`, `vsync_o` ⇐ `vsync`, `de_o` ⇐ `video_on`.
- Between advance edges all registers hold their values.
- Reset values:
  - `pix_x`=H_TOTAL-1, `pix_y`=V_TOTAL-1, `div_cnt`=0
  - `video_on`=0, `hsync`=`vsync`=~SYNC_POL
  - `p_tick`=`line_start`=`frame_start`=0
  - `rgb_o`=0, `de_o`=0, `hsync_o`=`vsync_o`=~SYNC_POL
- The first advance edge after reset release wraps the counters to (0,0) and produces `frame_start`.
- Reset asserted mid-frame forces all reset values immediately, regardless of clk. No partial line is completed.
- Every line passes through (0,y). `pix_y` passes through 481 with `pix_x`=0, as required by the game's per-frame update tick.

## Timing
- First advance edge after reset release: DIV clk edges after release.
- Coordinate period: DIV clks per pixel. Line period: 800·DIV clks. Frame period: 420000·DIV clks.
- `hsync`/`vsync`/`video_on` are valid in the same cycle as the coordinates they describe: zero skew.
- Game logic is combinational from `pix_x`/`pix_y`. Its result is captured at the end of the pixel period.
- `rgb_o`/`hsync_o`/`vsync_o`/`de_o` lag `pix_x` by exactly one pixel period (DIV clks), all mutually aligned.
- Strobes are exactly one clk wide for any DIV.

## Test plan
- Reset/start-up, DIV=1: hold `reset`=0 and check every reset value. Release and check first edge: `pix_x`=0, `pix_y`=0, `frame_start`=1, `video_on`=1. `frame_start` must be 0 on the next clk.
- Line timing, DIV=1:
  - `hsync`=0 for exactly 96 clks starting at `pix_x`=656.
  - `video_on` high for 640 clks per visible line.
  - `line_start` every 800 clks.
- Frame timing:
  - `vsync`=0 exactly on lines 490..491.
  - `frame_start` period is 420000 clks.
  - `pix_y` reaches 524 and wraps to 0.
  - (`pix_y`=481, `pix_x`=0) occurs once per frame.
- DIV=4:
  - `p_tick` every 4th clk.
  - Counters stable for 4 clks.
  - Line period 3200 clks.
  - `rgb_o` lags coordinates by 4 clks.
- Output stage:
  - Drive `graph_on`=1, `graph_rgb`=3'b110 only while `pix_x`=100..149, `pix_y`=353.
  - Expect `rgb_o`=3'b110 with `de_o`=1 one pixel later for exactly 50 pixels, and BG_RGB elsewhere in the visible area.
  - Expect `rgb_o`=0 in blanking even when `graph_on`=1.
- Mid-frame reset: assert `reset`=0 at (`pix_x`=300, `pix_y`=200) between clk edges. Outputs must reach reset values asynchronously. After release, the frame must restart cleanly at (0,0) with `frame_start`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters, zero-skew sync/status and a one-pixel-delayed colour output stage
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int DIV = 1,
    parameter logic SYNC_POL = 1'b0,
    parameter logic [2:0] BG_RGB = 3'b000
) (
    input logic clk,
    input logic reset,
    input logic graph_on,
    input logic [2:0] graph_rgb,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic p_tick,
    output logic video_on,
    output logic hsync,
    output logic vsync,
    output logic line_start,
    output logic frame_start,
    output logic [2:0] rgb_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic de_o
);
    localparam logic [9:0] H_MAX = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic [3:0] DIV_MAX = 4'(DIV - 1);

    logic [3:0] div_cnt_q, div_cnt_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic video_on_q, video_on_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic p_tick_q, p_tick_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [2:0] rgb_o_q, rgb_o_d;
    logic hsync_o_q, hsync_o_d, vsync_o_q, vsync_o_d, de_o_q, de_o_d;
    logic adv, x_wrap;

    // status flops are fed from the next coordinates so they never lag pix_x/pix_y
    always_comb begin
        adv = div_cnt_q == DIV_MAX;
        x_wrap = pix_x_q == H_MAX;
        div_cnt_d = adv ? 4'd0 : div_cnt_q + 4'd1;
        pix_x_d = !adv ? pix_x_q : (x_wrap ? 10'd0 : pix_x_q + 10'd1);
        pix_y_d = !(adv && x_wrap) ? pix_y_q : (pix_y_q == V_MAX ? 10'd0 : pix_y_q + 10'd1);
        video_on_d = pix_x_d < H_VIS && pix_y_d < V_VIS;
        hsync_d = (pix_x_d >= HS_FIRST && pix_x_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (pix_y_d >= VS_FIRST && pix_y_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        p_tick_d = adv;
        line_start_d = adv && pix_x_d == 10'd0;
        frame_start_d = adv && pix_x_d == 10'd0 && pix_y_d == 10'd0;
        rgb_o_d = !adv ? rgb_o_q : (!video_on_q ? 3'b000 : (graph_on ? graph_rgb : BG_RGB));
        hsync_o_d = adv ? hsync_q : hsync_o_q;
        vsync_o_d = adv ? vsync_q : vsync_o_q;
        de_o_d = adv ? video_on_q : de_o_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= 4'd0;
            pix_x_q <= H_MAX;
            pix_y_q <= V_MAX;
            video_on_q <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            p_tick_q <= 1'b0;
            line_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_o_q <= 3'b000;
            hsync_o_q <= ~SYNC_POL;
            vsync_o_q <= ~SYNC_POL;
            de_o_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            video_on_q <= video_on_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            p_tick_q <= p_tick_d;
            line_start_q <= line_start_d;
            frame_start_q <= frame_start_d;
            rgb_o_q <= rgb_o_d;
            hsync_o_q <= hsync_o_d;
            vsync_o_q <= vsync_o_d;
            de_o_q <= de_o_d;
        end
    end

    assign pix_x = pix_x_q;
    assign pix_y = pix_y_q;
    assign p_tick = p_tick_q;
    assign video_on = video_on_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign line_start = line_start_q;
    assign frame_start = frame_start_q;
    assign rgb_o = rgb_o_q;
    assign hsync_o = hsync_o_q;
    assign vsync_o = vsync_o_q;
    assign de_o = de_o_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default, scaled-down DIV=1 and scaled-down DIV=4 instances checked every clk against an elapsed-time raster model
module tb_vga_timing_gen;
    localparam int HD[3] = '{640, 40, 40};
    localparam int HF[3] = '{16, 4, 4};
    localparam int HS[3] = '{96, 8, 8};
    localparam int HB[3] = '{48, 6, 6};
    localparam int VD[3] = '{480, 30, 30};
    localparam int VF[3] = '{10, 3, 3};
    localparam int VS[3] = '{2, 2, 2};
    localparam int VB[3] = '{33, 4, 4};
    localparam int DV[3] = '{1, 1, 4};
    localparam int POL[3] = '{0, 1, 0};
    localparam int BG[3] = '{0, 3, 5};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic graph_on = 1'b0;
    logic [2:0] graph_rgb = 3'b000;
    logic [9:0] px[3], py[3];
    logic [2:0] rgbo[3];
    logic pt[3], von[3], hs[3], vs[3], ls[3], fs[3], hso[3], vso[3], deo[3];

    int tests = 0, fails = 0, cyc = 0, mode = 0, win_cnt = 0;
    int last_fs = -1, last_ls = -1, last_pt = -1;
    int c[3];
    logic [2:0] p_rgb[3], e_rgb[3];
    logic p_h[3], p_v[3], p_de[3], e_h[3], e_v[3], e_de[3];

    always #5 clk = ~clk;

    vga_timing_gen #(.H_DISPLAY(HD[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_DISPLAY(VD[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]), .DIV(DV[0]),
        .SYNC_POL(POL[0] != 0), .BG_RGB(3'(BG[0]))) dut0 (
        .clk(clk), .reset(reset), .graph_on(graph_on), .graph_rgb(graph_rgb),
        .pix_x(px[0]), .pix_y(py[0]), .p_tick(pt[0]), .video_on(von[0]), .hsync(hs[0]), .vsync(vs[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .rgb_o(rgbo[0]), .hsync_o(hso[0]), .vsync_o(vso[0]), .de_o(deo[0]));

    vga_timing_gen #(.H_DISPLAY(HD[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_DISPLAY(VD[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]), .DIV(DV[1]),
        .SYNC_POL(POL[1] != 0), .BG_RGB(3'(BG[1]))) dut1 (
        .clk(clk), .reset(reset), .graph_on(graph_on), .graph_rgb(graph_rgb),
        .pix_x(px[1]), .pix_y(py[1]), .p_tick(pt[1]), .video_on(von[1]), .hsync(hs[1]), .vsync(vs[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .rgb_o(rgbo[1]), .hsync_o(hso[1]), .vsync_o(vso[1]), .de_o(deo[1]));

    vga_timing_gen #(.H_DISPLAY(HD[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
        .V_DISPLAY(VD[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]), .DIV(DV[2]),
        .SYNC_POL(POL[2] != 0), .BG_RGB(3'(BG[2]))) dut2 (
        .clk(clk), .reset(reset), .graph_on(graph_on), .graph_rgb(graph_rgb),
        .pix_x(px[2]), .pix_y(py[2]), .p_tick(pt[2]), .video_on(von[2]), .hsync(hs[2]), .vsync(vs[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .rgb_o(rgbo[2]), .hsync_o(hso[2]), .vsync_o(vso[2]), .de_o(deo[2]));

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    // raster position after cc clk edges since release: pixel n-1 of the frame-long pixel sequence
    function automatic void model(input int d, input int cc, output int x, output int y,
                                  output logic v, output logic h, output logic vv,
                                  output logic p, output logic l, output logic f);
        int n, ht, vt, k;
        logic pl;
        n = cc / DV[d];
        ht = HD[d] + HF[d] + HS[d] + HB[d];
        vt = VD[d] + VF[d] + VS[d] + VB[d];
        pl = POL[d] != 0;
        if (n == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            k = (n - 1) % (ht * vt);
            x = k % ht;
            y = k / ht;
        end
        v = n > 0 && x < HD[d] && y < VD[d];
        h = (n > 0 && x >= HD[d] + HF[d] && x < HD[d] + HF[d] + HS[d]) ? pl : !pl;
        vv = (n > 0 && y >= VD[d] + VF[d] && y < VD[d] + VF[d] + VS[d]) ? pl : !pl;
        p = cc > 0 && cc % DV[d] == 0;
        l = p && x == 0;
        f = l && y == 0;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 3; d++) begin
            c[d] = 0;
            e_rgb[d] = 3'b000;
            e_h[d] = POL[d] == 0;
            e_v[d] = POL[d] == 0;
            e_de[d] = 1'b0;
        end
        last_fs = -1;
        last_ls = -1;
        last_pt = -1;
    endtask

    task automatic compare_all();
        int x, y;
        logic v, h, vv, p, l, f;
        for (int d = 0; d < 3; d++) begin
            model(d, c[d], x, y, v, h, vv, p, l, f);
            chk("pix_x", d, 32'(px[d]), x);
            chk("pix_y", d, 32'(py[d]), y);
            chk("video_on", d, 32'(von[d]), 32'(v));
            chk("hsync", d, 32'(hs[d]), 32'(h));
            chk("vsync", d, 32'(vs[d]), 32'(vv));
            chk("p_tick", d, 32'(pt[d]), 32'(p));
            chk("line_start", d, 32'(ls[d]), 32'(l));
            chk("frame_start", d, 32'(fs[d]), 32'(f));
            chk("rgb_o", d, 32'(rgbo[d]), 32'(e_rgb[d]));
            chk("hsync_o", d, 32'(hso[d]), 32'(e_h[d]));
            chk("vsync_o", d, 32'(vso[d]), 32'(e_v[d]));
            chk("de_o", d, 32'(deo[d]), 32'(e_de[d]));
        end
    endtask

    task automatic drive_inputs();
        int x, y;
        logic v, h, vv, p, l, f, win;
        if (mode == 0) begin
            graph_on = 1'($urandom_range(0, 1));
            graph_rgb = 3'($urandom);
        end else begin
            model(1, c[1], x, y, v, h, vv, p, l, f);
            win = x >= 10 && x <= 19 && y == 7;
            graph_on = win || (!v && $urandom_range(0, 1) == 1);
            graph_rgb = win ? 3'b110 : 3'($urandom);
        end
    endtask

    task automatic step(input logic release_now);
        int x, y;
        logic v, h, vv, p, l, f;
        @(negedge clk);
        if (release_now) reset = 1'b1;
        drive_inputs();
        for (int d = 0; d < 3; d++) begin
            if (reset && (c[d] + 1) % DV[d] == 0) begin
                model(d, c[d], x, y, v, h, vv, p, l, f);
                p_rgb[d] = !v ? 3'b000 : (graph_on ? graph_rgb : 3'(BG[d]));
                p_h[d] = h;
                p_v[d] = vv;
                p_de[d] = v;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                c[d]++;
                if (c[d] % DV[d] == 0) begin
                    e_rgb[d] = p_rgb[d];
                    e_h[d] = p_h[d];
                    e_v[d] = p_v[d];
                    e_de[d] = p_de[d];
                end
            end
        end
        compare_all();
        if (fs[1]) begin
            if (last_fs >= 0) chk("frame_period", 1, cyc - last_fs, 2262);
            last_fs = cyc;
        end
        if (ls[0]) begin
            if (last_ls >= 0) chk("line_period", 0, cyc - last_ls, 800);
            last_ls = cyc;
        end
        if (pt[2]) begin
            if (last_pt >= 0) chk("tick_period", 2, cyc - last_pt, 4);
            last_pt = cyc;
        end
        if (mode == 1 && deo[1] && rgbo[1] == 3'b110) win_cnt++;
    endtask

    initial begin
        int x, y;
        logic v, h, vv, p, l, f;
        reset_model();
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (10000) step(1'b0);
        for (int i = 0; i < 3000; i++) begin
            model(1, c[1], x, y, v, h, vv, p, l, f);
            if (x == 30 && y == 20) break;
            step(1'b0);
        end
        model(1, c[1], x, y, v, h, vv, p, l, f);
        chk("reach_mid_x", 1, px[1], 30);
        chk("reach_mid_y", 1, py[1], 20);
        #2;
        reset = 1'b0;
        reset_model();
        #1;
        compare_all();
        repeat (3) step(1'b0);
        mode = 1;
        step(1'b1);
        repeat (2600) step(1'b0);
        chk("window_pixels", 1, win_cnt, 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
